// File: rtl/seq_slice_adder.sv
// Sequential slice adder/subtractor: adds an N-bit operand pair K bits per
// clock, with a valid/ready handshake on both the input and the output side.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an operation; in_ready high
// RUN   | adding one K-bit slice per edge, low slice first
// DONE  | S holds the finished result; out_valid high until out_ready
module seq_slice_adder #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CIN,
  input  logic         SUB,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   S
);

  localparam int NS = N / K;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic          r_sub;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic [N:0]    r_s;

  logic [K:0]    w_sum;
  logic          w_last;
  logic          w_accept;

  // Subtraction arrives here as A + ~B + 1, so a single adder serves both modes.
  assign w_sum    = {1'b0, r_a[r_idx*K +: K]} + {1'b0, r_b[r_idx*K +: K]} + {{K{1'b0}}, r_carry};
  assign w_last   = (r_idx == IW'(NS - 1));
  assign w_accept = (r_state == IDLE) && in_valid;
  assign S        = r_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; handshake outputs depend on state only.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture on accept, then one slice of the sum per RUN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= SUB ? ~B : B;
      r_sub   <= SUB;
      r_carry <= SUB ? 1'b1 : CIN;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_s[r_idx*K +: K] <= w_sum[K-1:0];
      r_carry           <= w_sum[K];
      r_idx             <= r_idx + IW'(1);
      // Final carry of A + ~B + 1 is "no borrow", so invert it for subtract.
      if (w_last) r_s[N] <= w_sum[K] ^ r_sub;
    end
  end

endmodule

// File: tb/tb_seq_slice_adder.sv
// Bench for seq_slice_adder: directed vectors on an N=8/K=4 instance plus
// random operations on three N=16 instances (K = 1, 4, 16) sharing inputs.
module tb_seq_slice_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] A, B;
  logic       CIN, SUB;
  logic [8:0] S;

  logic        in_valid16, out_ready16, cin16, sub16;
  logic [15:0] a16, b16;
  logic        rdy_k1, rdy_k4, rdy_k16;
  logic        ov_k1, ov_k4, ov_k16;
  logic [16:0] s_k1, s_k4, s_k16;

  int n_checks = 0;
  int n_errors = 0;

  seq_slice_adder #(.N(8), .K(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .CIN(CIN), .SUB(SUB),
    .out_valid(out_valid), .out_ready(out_ready), .S(S)
  );

  seq_slice_adder #(.N(16), .K(1)) u_k1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(rdy_k1),
    .A(a16), .B(b16), .CIN(cin16), .SUB(sub16),
    .out_valid(ov_k1), .out_ready(out_ready16), .S(s_k1)
  );

  seq_slice_adder #(.N(16), .K(4)) u_k4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(rdy_k4),
    .A(a16), .B(b16), .CIN(cin16), .SUB(sub16),
    .out_valid(ov_k4), .out_ready(out_ready16), .S(s_k4)
  );

  seq_slice_adder #(.N(16), .K(16)) u_k16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(rdy_k16),
    .A(a16), .B(b16), .CIN(cin16), .SUB(sub16),
    .out_valid(ov_k16), .out_ready(out_ready16), .S(s_k16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete 8-bit operation; operands are scrambled right after accept.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub, input logic [8:0] exp_s);
    int lat;
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    A = a; B = b; CIN = cin; SUB = sub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; A = ~a; B = ~b; CIN = ~cin; SUB = ~sub;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd2);
    check({tag, ".S"}, 32'(S), 32'(exp_s));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".idle_ov"}, 32'(out_valid), 32'd0);
    check({tag, ".idle_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int         lat;
    int         acc_cyc[2];
    int         na, nr;
    int         seen;
    logic [7:0] pa[2];
    logic [7:0] pb[2];
    logic [8:0] pexp[2];

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; CIN = 1'b0; SUB = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    #12;
    check("rst.S", 32'(S), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    do_op("add_small", 8'h04, 8'h02, 1'b0, 1'b0, 9'h006);
    do_op("add_max",   8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF);
    do_op("add_carry", 8'h80, 8'h80, 1'b0, 1'b0, 9'h100);
    do_op("sub_pos",   8'h05, 8'h01, 1'b0, 1'b1, 9'h004);
    do_op("sub_borrow",8'h03, 8'h0B, 1'b0, 1'b1, 9'h1F8);
    do_op("sub_equal", 8'h0A, 8'h0A, 1'b0, 1'b1, 9'h000);
    do_op("sub_cin",   8'h10, 8'h01, 1'b1, 1'b1, 9'h00F);

    // Backpressure: result held in DONE while out_ready stays low.
    @(negedge clk);
    A = 8'h20; B = 8'h0D; CIN = 1'b0; SUB = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp.latency", 32'(lat), 32'd2);
    A = 8'h77; B = 8'h11; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp.S", 32'(S), 32'h02D);
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check("bp.in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp.release_ov", 32'(out_valid), 32'd0);
    check("bp.release_rdy", 32'(in_ready), 32'd1);

    // Back-to-back with in_valid and out_ready held high.
    pa[0] = 8'h0F; pb[0] = 8'h0F; pexp[0] = 9'h01E;
    pa[1] = 8'h0B; pb[1] = 8'h03; pexp[1] = 9'h00E;
    na = 0; nr = 0;
    out_ready = 1'b1; CIN = 1'b0; SUB = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (na < 2) begin
        A = pa[na]; B = pb[na]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && nr < 2) begin
        check("b2b.S", 32'(S), 32'(pexp[nr]));
        nr++;
      end
      if (in_ready && in_valid && na < 2) begin
        acc_cyc[na] = cyc;
        na++;
      end
    end
    out_ready = 1'b0; in_valid = 1'b0;
    check("b2b.accepts", 32'(na), 32'd2);
    check("b2b.results", 32'(nr), 32'd2);
    check("b2b.interval", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    A = 8'hFF; B = 8'h01; CIN = 1'b0; SUB = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_run.S", 32'(S), 32'd0);
    check("rst_run.out_valid", 32'(out_valid), 32'd0);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_run.stale", 32'(seen), 32'd0);
    do_op("after_rst", 8'h12, 8'h34, 1'b1, 1'b0, 9'h047);

    // N=16 sweep: K=1, 4, 16 against a reference model.
    for (int op = 0; op < 40; op++) begin
      logic [16:0] exp16;
      int          l1, l4, l16, c;
      logic [16:0] r1, r4, r16;
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom);
      cin16 = 1'($urandom); sub16 = 1'($urandom);
      if (op == 0) begin a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1; sub16 = 1'b0; end
      if (op == 1) begin a16 = 16'h0001; b16 = 16'h0002; sub16 = 1'b1; end
      exp16 = sub16 ? {(a16 < b16), 16'(a16 - b16)}
                    : {1'b0, a16} + {1'b0, b16} + 17'(cin16);
      check("sw.ready", 32'({rdy_k1, rdy_k4, rdy_k16}), 32'h7);
      in_valid16 = 1'b1;
      @(negedge clk);
      in_valid16 = 1'b0; a16 = ~a16; b16 = ~b16;
      l1 = -1; l4 = -1; l16 = -1; c = 0;
      r1 = '0; r4 = '0; r16 = '0;
      while ((l1 < 0 || l4 < 0 || l16 < 0) && c < 40) begin
        @(negedge clk);
        c++;
        if (ov_k1 && l1 < 0)   begin l1 = c;  r1 = s_k1;  end
        if (ov_k4 && l4 < 0)   begin l4 = c;  r4 = s_k4;  end
        if (ov_k16 && l16 < 0) begin l16 = c; r16 = s_k16; end
      end
      check("sw.k1.lat", 32'(l1), 32'd16);
      check("sw.k4.lat", 32'(l4), 32'd4);
      check("sw.k16.lat", 32'(l16), 32'd1);
      check("sw.k1.S", 32'(r1), 32'(exp16));
      check("sw.k4.S", 32'(r4), 32'(exp16));
      check("sw.k16.S", 32'(r16), 32'(exp16));
      out_ready16 = 1'b1;
      @(negedge clk);
      out_ready16 = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
